player_ctrl: RTL and testbench
==============================

// Module: player_ctrl
// PURPOSE
//   Owns player state for the bar-dodging game: horizontal column, vertical position and level.
//   Sits directly upstream of the collision/score stage: drives player_h, player_v and level into it,
//   and consumes its reset_player (collision/respawn) request.
//   Moves the player from button inputs, paced by the per-frame tick from the VGA timing block.
// PARAMETERS
//   H_START   40   player_h of column 0 (player centre, px)
//   COL_W     80   column pitch (px); one right-press advances one column
//   NUM_COLS  8    columns 0..NUM_COLS-1; reaching the last column completes a level
//   H_STEP    8    px per tick during a horizontal move; must divide COL_W
//   V_START   240  player_v after reset/respawn
//   V_STEP    4    px per tick while up/down is held
//   V_MIN     20   lowest legal player_v (half player height)
//   V_MAX     460  highest legal player_v
//   MAX_LEVEL 15   level saturates here
// PORTS
//   clk           in   1   system clock (one clock domain)
//   reset_n       in   1   asynchronous active-low reset
//   tick          in   1   one-cycle pulse per frame; all motion is applied only on tick cycles
//   btn_up        in   1   raw button level (async); move up while held
//   btn_down      in   1   raw button level (async); move down while held
//   btn_right     in   1   raw button level (async); rising edge starts a one-column move
//   reset_player  in   1   respawn request from collision stage; level-sensitive, held >=1 cycle
//   player_h      out  10  player centre x (px)
//   player_v      out  10  player centre y (px)
//   level         out  10  completed levels, 0..MAX_LEVEL
//   moving        out  1   high while a horizontal move is in progress
// BEHAVIOUR
//   Reset (reset_n=0, async): player_h=H_START, player_v=V_START, level=0, moving=0, state IDLE,
//     synchronisers/edge registers cleared to 0.
//   Inputs: each btn_* goes through a 2-flop synchroniser. The btn_right edge is detected on the
//     synchronised level (rise = cur & ~prev). Press-to-state latency is 3 clk.
//   FSM: IDLE, MOVE_H, RESPAWN.
//     IDLE:    on a btn_right rise: target=player_h+COL_W, moving=1, go to MOVE_H.
//     MOVE_H:  on each tick, player_h+=H_STEP. When player_h==target:
//              if the column is NUM_COLS-1 (player_h==H_START+(NUM_COLS-1)*COL_W):
//                player_h=H_START; level=min(level+1,MAX_LEVEL).
//              Then moving=0 and go to IDLE in the same cycle. btn_right rises here are dropped.
//     RESPAWN: entered from any state whenever reset_player=1. Sets player_h=H_START,
//              player_v=V_START, level=0, moving=0. Stays while reset_player=1.
//              On release, goes to IDLE one cycle later. A btn_right edge seen on the release cycle is dropped.
//   Vertical: applies in IDLE and MOVE_H, on tick only.
//     up&~down: player_v=max(player_v-V_STEP, V_MIN). down&~up: player_v=min(player_v+V_STEP, V_MAX).
//     Both or neither held: no change. Clamp arithmetic is 11-bit, so there is no underflow or wrap.
//   Priority: reset_n > reset_player > level-complete > step > vertical. If a respawn arrives in
//     the same cycle as level completion, respawn wins and level=0.
//   Outputs are registered and change only on clk edges (or async reset). There are no combinational paths to them.
// STRUCTURE
//   Shared game package: screen constants (H_START, COL_W, NUM_COLS, V_MIN, V_MAX, player half-size 20)
//     and the FSM state encoding. The same constants feed the collision/score stage and the renderer.
//   One natural sub-module, btn_sync: a 2-flop synchroniser plus previous-value register,
//     outputs level and rise. Instantiate it 3x.
// TESTING
//   1 Reset: hold reset_n=0 mid-move -> h=40, v=240, level=0, moving=0 immediately, with no clk needed.
//   2 One right press, ticks every 4 clk -> moving=1 3 clk after the press; h steps 40,48,..,120
//     over 10 ticks; moving=0 at h=120. A second press during the move is ignored (h stays 120).
//   3 Seven presses from column 0 -> at the 7th arrival h=600 is never held: h returns to 40 and level=1.
//     With level=15, repeat the sequence -> level stays 15.
//   4 Hold btn_up from v=240 for 60 ticks -> v reaches 20 after 55 ticks and stays at 20.
//     Hold both up and down -> v unchanged. Hold down -> v clamps at 460.
//   5 reset_player pulse for 2 clk during MOVE_H at h=88, level=3 -> h=40, v=240, level=0, moving=0.
//     A btn_right press held before release does not start a move; a new press after release does.
//   6 No tick for 1000 clk with buttons held -> no position change, but an edge still enters MOVE_H (moving=1).

Source files
------------

// File: rtl/player_ctrl_pkg.sv
// Shared game constants and the player FSM encoding. The collision/score
// stage and the renderer import the same screen geometry from here.
package player_ctrl_pkg;

    // Horizontal geometry: column 0 centre, column pitch, per-tick step.
    localparam int         NUM_COLS    = 8;
    localparam logic [9:0] H_START     = 10'd40;
    localparam logic [9:0] COL_W       = 10'd80;
    localparam logic [9:0] H_STEP      = 10'd8;

    // Vertical geometry: spawn height, per-tick step and legal range.
    localparam logic [9:0] V_START     = 10'd240;
    localparam logic [9:0] V_STEP      = 10'd4;
    localparam logic [9:0] V_MIN       = 10'd20;
    localparam logic [9:0] V_MAX       = 10'd460;

    // Player sprite half-size, used by collision and rendering.
    localparam logic [9:0] PLAYER_HALF = 10'd20;

    // Level counter saturates here.
    localparam logic [9:0] MAX_LEVEL   = 10'd15;

    // Centre of the last column; arriving here completes a level.
    localparam logic [9:0] LAST_H      = H_START + COL_W * 10'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE_H  = 2'd1,
        ST_RESPAWN = 2'd2
    } player_state_e;

    // Increment that sticks at the given ceiling.
    function automatic logic [9:0] sat_inc(input logic [9:0] x, input logic [9:0] ceil_v);
        return (x >= ceil_v) ? ceil_v : x + 10'd1;
    endfunction

endpackage

// File: rtl/player_ctrl_btn_sync.sv
// Two-flop synchroniser for one asynchronous button, plus a previous-value
// register so the owner gets both the clean level and a single-cycle rise.
module player_ctrl_btn_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain followed by the edge-detect history flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/player_ctrl.sv
// Player state for the bar-dodging game: column position, height and level.
// Motion is applied only on the per-frame tick; a respawn request from the
// collision stage overrides everything except the hard reset.
module player_ctrl
    import player_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_right,
    input  logic          reset_player,
    output logic [9:0]    player_h,
    output logic [9:0]    player_v,
    output logic [9:0]    level,
    output logic          moving,
    output player_state_e fsm_state
);

    logic up_lvl, up_rise;
    logic dn_lvl, dn_rise;
    logic rt_lvl, rt_rise;

    player_ctrl_btn_sync u_sync_up (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_up),
        .level_o (up_lvl),
        .rise_o  (up_rise)
    );

    player_ctrl_btn_sync u_sync_down (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_down),
        .level_o (dn_lvl),
        .rise_o  (dn_rise)
    );

    player_ctrl_btn_sync u_sync_right (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_right),
        .level_o (rt_lvl),
        .rise_o  (rt_rise)
    );

    // Only the right button is edge-driven; the others are used as levels.
    logic unused_sync;
    assign unused_sync = up_rise ^ dn_rise ^ rt_lvl;

    player_state_e state_q;
    logic [9:0]    h_q;
    logic [9:0]    v_q;
    logic [9:0]    level_q;
    logic          moving_q;
    logic [9:0]    target_q;

    logic [10:0]   v_up_d;
    logic [10:0]   v_dn_d;
    logic [9:0]    v_d;
    logic [9:0]    h_step_d;

    // Clamped vertical candidate in 11-bit arithmetic so the edges never wrap.
    always_comb begin
        v_up_d   = {1'b0, v_q} - {1'b0, V_STEP};
        v_dn_d   = {1'b0, v_q} + {1'b0, V_STEP};
        h_step_d = h_q + H_STEP;
        v_d      = v_q;
        if (up_lvl && !dn_lvl) begin
            v_d = (v_up_d[10] || (v_up_d < {1'b0, V_MIN})) ? V_MIN : v_up_d[9:0];
        end else if (dn_lvl && !up_lvl) begin
            v_d = (v_dn_d > {1'b0, V_MAX}) ? V_MAX : v_dn_d[9:0];
        end
    end

    // Player FSM: respawn > level complete > horizontal step > vertical.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            h_q      <= H_START;
            v_q      <= V_START;
            level_q  <= '0;
            moving_q <= 1'b0;
            target_q <= H_START;
        end else if (reset_player) begin
            state_q  <= ST_RESPAWN;
            h_q      <= H_START;
            v_q      <= V_START;
            level_q  <= '0;
            moving_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        v_q <= v_d;
                    end
                    if (rt_rise) begin
                        target_q <= h_q + COL_W;
                        moving_q <= 1'b1;
                        state_q  <= ST_MOVE_H;
                    end
                end
                ST_MOVE_H: begin
                    // Right-button rises are ignored while a move is underway.
                    if (tick) begin
                        v_q <= v_d;
                        if (h_step_d == target_q) begin
                            // The last column is never held: wrap and score.
                            if (target_q == LAST_H) begin
                                h_q     <= H_START;
                                level_q <= sat_inc(level_q, MAX_LEVEL);
                            end else begin
                                h_q <= h_step_d;
                            end
                            moving_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            h_q <= h_step_d;
                        end
                    end
                end
                ST_RESPAWN: begin
                    // Release cycle: any right edge seen now is dropped.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign player_h  = h_q;
    assign player_v  = v_q;
    assign level     = level_q;
    assign moving    = moving_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: table-driven vertical vectors plus
// hand-written sequences for moves, level wrap, respawn and tick gating.
module tb_player_ctrl;
    import player_ctrl_pkg::*;

    // Expected geometry written out independently of the package.
    localparam int E_H0     = 40;
    localparam int E_COL    = 80;
    localparam int E_HSTEP  = 8;
    localparam int E_V0     = 240;
    localparam int E_LASTH  = 600;
    localparam int E_MAXLVL = 15;
    localparam int E_HTICKS = 10;

    logic          clk          = 1'b0;
    logic          reset_n      = 1'b1;
    logic          tick         = 1'b0;
    logic          btn_up       = 1'b0;
    logic          btn_down     = 1'b0;
    logic          btn_right    = 1'b0;
    logic          reset_player = 1'b0;
    logic [9:0]    player_h;
    logic [9:0]    player_v;
    logic [9:0]    level;
    logic          moving;
    player_state_e fsm_state;

    int checks = 0;
    int errors = 0;
    logic [30:0] exp_q[$];

    typedef struct {
        logic up;
        logic down;
        int   ticks;
        int   exp_v;
    } vvec_t;
    vvec_t vt[10];

    // Clock generation.
    always #5 clk = ~clk;

    player_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_right    (btn_right),
        .reset_player (reset_player),
        .player_h     (player_h),
        .player_v     (player_v),
        .level        (level),
        .moving       (moving),
        .fsm_state    (fsm_state)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(1);
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the outputs now.
    task automatic sb_compare(input string name);
        logic [30:0] e;
        e = exp_q.pop_front();
        cmp({name, ".h"},      int'(player_h), int'(e[30:21]));
        cmp({name, ".v"},      int'(player_v), int'(e[20:11]));
        cmp({name, ".level"},  int'(level),    int'(e[10:1]));
        cmp({name, ".moving"}, int'(moving),   int'(e[0]));
    endtask

    task automatic push_exp(input int h, input int v, input int lvl, input int mv);
        logic [9:0] hh, vv, ll;
        hh = h[9:0];
        vv = v[9:0];
        ll = lvl[9:0];
        exp_q.push_back({hh, vv, ll, mv[0]});
    endtask

    // Compare on the next falling edge.
    task automatic expect_st(input string name, input int h, input int v, input int lvl, input int mv);
        push_exp(h, v, lvl, mv);
        @(negedge clk);
        sb_compare(name);
    endtask

    // Compare immediately, with no clock edge in between.
    task automatic expect_now(input string name, input int h, input int v, input int lvl, input int mv);
        push_exp(h, v, lvl, mv);
        sb_compare(name);
    endtask

    // Asynchronous reset away from the clock edge, checked before any edge.
    task automatic do_reset(input string name);
        btn_up = 1'b0; btn_down = 1'b0; btn_right = 1'b0;
        tick = 1'b0; reset_player = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 expect_now(name, E_H0, E_V0, 0, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(1);
    endtask

    // One right press and the full ten-tick move, checking every step.
    task automatic do_move(input int h0, input int v0, input int lvl0);
        int tgt;
        int h_end;
        int l_end;
        tgt = h0 + E_COL;
        btn_right = 1'b1;
        step(3);
        btn_right = 1'b0;
        expect_st("move_start", h0, v0, lvl0, 1);
        for (int i = 1; i <= E_HTICKS; i++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            if (i < E_HTICKS) expect_st("move_step", h0 + i * E_HSTEP, v0, lvl0, 1);
            else step(1);
        end
        if (tgt == E_LASTH) begin
            h_end = E_H0;
            l_end = (lvl0 >= E_MAXLVL) ? E_MAXLVL : lvl0 + 1;
        end else begin
            h_end = tgt;
            l_end = lvl0;
        end
        expect_st("move_end", h_end, v0, l_end, 0);
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b0, 54,  24};
        vt[1] = '{1'b1, 1'b0, 1,   20};
        vt[2] = '{1'b1, 1'b0, 5,   20};
        vt[3] = '{1'b1, 1'b1, 10,  20};
        vt[4] = '{1'b0, 1'b0, 10,  20};
        vt[5] = '{1'b0, 1'b1, 10,  60};
        vt[6] = '{1'b0, 1'b1, 100, 460};
        vt[7] = '{1'b0, 1'b1, 5,   460};
        vt[8] = '{1'b1, 1'b0, 1,   456};
        vt[9] = '{1'b1, 1'b1, 3,   456};

        // Power-on reset, checked without a clock edge.
        #1 reset_n = 1'b0;
        #1 expect_now("por", E_H0, E_V0, 0, 0);
        cmp("por.state", int'(fsm_state), int'(ST_IDLE));
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(2);

        // Single move with exact press latency and ticks every 4 clk.
        btn_right = 1'b1;
        step(2);
        expect_st("lat2", E_H0, E_V0, 0, 0);
        step(1);
        expect_st("lat3", E_H0, E_V0, 0, 1);
        btn_right = 1'b0;
        for (int i = 1; i <= E_HTICKS; i++) begin
            if (i == 5) btn_right = 1'b1;
            if (i == 8) btn_right = 1'b0;
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(3);
            expect_st("step4", E_H0 + i * E_HSTEP, E_V0, 0, (i < E_HTICKS) ? 1 : 0);
        end
        step(10);
        ticks(3);
        expect_st("second_press_ignored", 120, E_V0, 0, 0);

        // Asynchronous reset in the middle of a move.
        btn_right = 1'b1;
        step(3);
        btn_right = 1'b0;
        ticks(3);
        expect_st("mid_move", 144, E_V0, 0, 1);
        do_reset("reset_mid_move");

        // Seven moves complete a level; the last column is never held.
        for (int c = 0; c < 7; c++) do_move(E_H0 + c * E_COL, E_V0, 0);
        for (int l = 1; l < E_MAXLVL; l++) begin
            for (int c = 0; c < 7; c++) do_move(E_H0 + c * E_COL, E_V0, l);
        end
        expect_st("level_max", E_H0, E_V0, E_MAXLVL, 0);
        for (int c = 0; c < 7; c++) do_move(E_H0 + c * E_COL, E_V0, E_MAXLVL);
        expect_st("level_sat", E_H0, E_V0, E_MAXLVL, 0);

        // Vertical clamping vectors.
        do_reset("reset_vert");
        for (int r = 0; r < 10; r++) begin
            btn_up   = vt[r].up;
            btn_down = vt[r].down;
            step(3);
            ticks(vt[r].ticks);
            expect_st($sformatf("vert%0d", r), E_H0, vt[r].exp_v, 0, 0);
        end
        btn_up = 1'b0;
        btn_down = 1'b0;

        // Respawn during a move at h=88 with level 3.
        do_reset("reset_resp");
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 7; c++) do_move(E_H0 + c * E_COL, E_V0, l);
        end
        btn_down = 1'b1;
        step(3);
        ticks(5);
        btn_down = 1'b0;
        step(3);
        expect_st("pre_resp_v", E_H0, 260, 3, 0);
        btn_right = 1'b1;
        step(3);
        btn_right = 1'b0;
        ticks(6);
        expect_st("pre_resp_h", 88, 260, 3, 1);
        btn_right = 1'b1;
        reset_player = 1'b1;
        step(1);
        expect_st("resp_active", E_H0, E_V0, 0, 0);
        cmp("resp.state", int'(fsm_state), int'(ST_RESPAWN));
        step(1);
        reset_player = 1'b0;
        step(5);
        expect_st("resp_edge_dropped", E_H0, E_V0, 0, 0);
        cmp("resp_idle.state", int'(fsm_state), int'(ST_IDLE));
        btn_right = 1'b0;
        step(4);
        btn_right = 1'b1;
        step(3);
        expect_st("resp_new_press", E_H0, E_V0, 0, 1);
        btn_right = 1'b0;

        // No tick: held buttons do nothing, but an edge still starts a move.
        do_reset("reset_notick");
        btn_up = 1'b1;
        step(1000);
        expect_st("notick_hold", E_H0, E_V0, 0, 0);
        btn_right = 1'b1;
        step(3);
        expect_st("notick_edge", E_H0, E_V0, 0, 1);
        btn_right = 1'b0;
        btn_up = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
